// File: rtl/seg_scan_counter.sv
// Multi-digit hex/BCD up/down counter with a multiplexed 7-segment scan output.
// Count, carry, segment pattern and digit strobe are all registered.
module seg_scan_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned BCD      = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]  DMAX = (BCD != 0) ? 4'd9 : 4'hf;

    logic [CW-1:0]     count_q, count_d;
    logic              carry_q, carry_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;

    // Pattern order {g,f,e,d,c,b,a}, active-high
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3f;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5b;
            4'h3: s = 7'h4f;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6d;
            4'h6: s = 7'h7d;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7f;
            4'h9: s = 7'h6f;
            4'ha: s = 7'h77;
            4'hb: s = 7'h7c;
            4'hc: s = 7'h39;
            4'hd: s = 7'h5e;
            4'he: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Counter next state: load beats enable; ripple runs through every digit in one cycle
    logic [3:0] nib;
    logic       rip;
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        nib     = 4'd0;
        rip     = 1'b1;
        if (load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                nib = load_val[4*i +: 4];
                if ((BCD != 0) && (nib > 4'd9)) nib = 4'd9;
                count_d[4*i +: 4] = nib;
            end
        end else if (en) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                nib = count_q[4*i +: 4];
                if (rip) begin
                    if (up) begin
                        if (nib == DMAX) nib = 4'd0;
                        else begin
                            nib = nib + 4'd1;
                            rip = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) nib = DMAX;
                        else begin
                            nib = nib - 4'd1;
                            rip = 1'b0;
                        end
                    end
                end
                count_d[4*i +: 4] = nib;
            end
            // Ripple surviving past the top digit means every digit wrapped
            carry_d = rip;
        end
    end

    // Scan prescaler and digit index, free-running regardless of en/load
    always_comb begin
        presc_d = presc_q + PW'(1);
        scan_d  = scan_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            scan_d  = (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + SW'(1);
        end
    end

    // Strobe and segment pattern for the digit currently being scanned
    logic [3:0] cur;
    logic       zero_above;
    logic       blank;
    always_comb begin
        sel_d      = '0;
        cur        = 4'd0;
        zero_above = 1'b1;
        blank      = 1'b0;
        // Walk from the top so zero_above covers this digit and all higher ones
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
            if (SW'(i) == scan_q) begin
                sel_d[i] = 1'b1;
                cur      = count_q[4*i +: 4];
                blank    = blank_lz && zero_above && (i != 0);
            end
        end
        seg_d = blank ? 7'h00 : decode(cur);
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
            presc_q <= '0;
            scan_q  <= '0;
            seg_q   <= 7'h00;
            sel_q   <= '0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            presc_q <= presc_d;
            scan_q  <= scan_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign count     = count_q;
    assign carry     = carry_q;
    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Bench for seg_scan_counter: a hex and a BCD instance share stimulus and are
// compared against an integer-arithmetic reference model.
module tb_seg_scan_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0, up = 1'b0, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] load_val = 16'h0;

    logic [15:0] count_h, count_b;
    logic        carry_h, carry_b;
    logic [6:0]  seg_h, seg_b;
    logic [3:0]  sel_h, sel_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int         m_hex, m_bcd, m_edge;
    logic       m_carry_h, m_carry_b;
    logic [6:0] m_seg_h, m_seg_b;
    logic [3:0] m_sel;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clock = ~clock;

    seg_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .BCD(0)) dut (
        .clock(clock), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count(count_h), .carry(carry_h),
        .seg(seg_h), .digit_sel(sel_h)
    );

    seg_scan_counter #(.DIGITS(4), .SCAN_DIV(4), .BCD(1)) dut_bcd (
        .clock(clock), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count(count_b), .carry(carry_b),
        .seg(seg_b), .digit_sel(sel_b)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal value of a loaded word, each nibble clamped to 9
    function automatic int bcd_of(input logic [15:0] lv);
        int val, mul, d;
        val = 0;
        mul = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            val = val + d * mul;
            mul = mul * 10;
        end
        return val;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx);
        logic [15:0] hi;
        hi = v >> (4 * idx);
        if (blank_lz && idx > 0 && hi == 16'h0) return 7'h00;
        return seg_tab[hi[3:0]];
    endfunction

    task automatic model_reset();
        m_hex = 0; m_bcd = 0; m_edge = 0;
        m_carry_h = 1'b0; m_carry_b = 1'b0;
        m_seg_h = 7'h00; m_seg_b = 7'h00; m_sel = 4'h0;
    endtask

    // One clock edge: model follows the inputs sampled at the edge; returns at the negedge
    task automatic step();
        int idx;
        @(posedge clock);
        idx       = (m_edge / SCAN_DIV) % DIGITS;
        m_sel     = 4'(1 << idx);
        m_seg_h   = exp_seg(16'(m_hex), idx);
        m_seg_b   = exp_seg(to_bcd(m_bcd), idx);
        m_edge    = m_edge + 1;
        m_carry_h = 1'b0;
        m_carry_b = 1'b0;
        if (load) begin
            m_hex = int'(load_val);
            m_bcd = bcd_of(load_val);
        end else if (en && up) begin
            m_carry_h = (m_hex == 65535);
            m_hex     = (m_hex + 1) % 65536;
            m_carry_b = (m_bcd == 9999);
            m_bcd     = (m_bcd + 1) % 10000;
        end else if (en) begin
            m_carry_h = (m_hex == 0);
            m_hex     = (m_hex + 65535) % 65536;
            m_carry_b = (m_bcd == 0);
            m_bcd     = (m_bcd + 9999) % 10000;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clock);
        n_checks++;
        if ({count_h, carry_h, seg_h, sel_h} !== 28'h0)
            $display("FAIL reset_hex got %h want 0", {count_h, carry_h, seg_h, sel_h});
        else n_pass++;
        n_checks++;
        if ({count_b, carry_b, seg_b, sel_b} !== 28'h0)
            $display("FAIL reset_bcd got %h want 0", {count_b, carry_b, seg_b, sel_b});
        else n_pass++;
        reset_n = 1'b1;
        step();
        n_checks++;
        if (sel_h !== 4'b0001 || seg_h !== 7'h3F)
            $display("FAIL first_edge sel=%b seg=%h want 0001 3f", sel_h, seg_h);
        else n_pass++;
    endtask

    task automatic test_ripple();
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h00FF;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (count_h !== 16'h0100 || carry_h !== 1'b0)
            $display("FAIL ripple_00ff count=%h carry=%b want 0100 0", count_h, carry_h);
        else n_pass++;
        load = 1'b1; load_val = 16'hFFFF;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (count_h !== 16'h0000 || carry_h !== 1'b1)
            $display("FAIL wrap_up count=%h carry=%b want 0000 1", count_h, carry_h);
        else n_pass++;
        en = 1'b0;
        step();
        n_checks++;
        if (carry_h !== 1'b0)
            $display("FAIL carry_pulse carry=%b want 0", carry_h);
        else n_pass++;
    endtask

    task automatic test_bcd();
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h0999;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (count_b !== 16'h1000)
            $display("FAIL bcd_up count=%h want 1000", count_b);
        else n_pass++;
        load = 1'b1; load_val = 16'h0000;
        step();
        load = 1'b0; up = 1'b0;
        step();
        n_checks++;
        if (count_b !== 16'h9999 || carry_b !== 1'b1)
            $display("FAIL bcd_down count=%h carry=%b want 9999 1", count_b, carry_b);
        else n_pass++;
        en = 1'b0; load = 1'b1; load_val = 16'h00A5;
        step();
        load = 1'b0;
        n_checks++;
        if (count_b !== 16'h0095 || carry_b !== 1'b0)
            $display("FAIL bcd_sat count=%h carry=%b want 0095 0", count_b, carry_b);
        else n_pass++;
    endtask

    task automatic test_scan();
        logic [6:0] pat [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        int errs;
        int idx;
        errs = 0;
        en = 1'b0; blank_lz = 1'b0; load = 1'b1; load_val = 16'h1234;
        step();
        load = 1'b0;
        step();
        for (int k = 0; k < 32; k++) begin
            idx = ((m_edge) / SCAN_DIV) % DIGITS;
            step();
            n_checks++;
            if (sel_h !== 4'(1 << idx) || seg_h !== pat[idx] || seg_h !== m_seg_h) begin
                $display("FAIL scan_1234 k=%0d sel=%b seg=%h want %b %h", k, sel_h, seg_h,
                         4'(1 << idx), pat[idx]);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_blank();
        int idx;
        en = 1'b0; load = 1'b1; load_val = 16'h0007; blank_lz = 1'b1;
        step();
        load = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            blank_lz = (pass == 0);
            for (int k = 0; k < 16; k++) begin
                idx = ((m_edge) / SCAN_DIV) % DIGITS;
                step();
                n_checks++;
                if (seg_h !== (idx == 0 ? 7'h07 : (blank_lz ? 7'h00 : 7'h3F)))
                    $display("FAIL blank lz=%b digit=%0d seg=%h", blank_lz, idx, seg_h);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h3FFE;
        step();
        load = 1'b0;
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({count_h, carry_h, seg_h, sel_h, count_b, carry_b, seg_b, sel_b} !== 56'h0)
            $display("FAIL async_reset count=%h seg=%h sel=%b want 0", count_h, seg_h, sel_h);
        else n_pass++;
        model_reset();
        #1 reset_n = 1'b1;
        step();
        n_checks++;
        if (count_h !== 16'h0001 || carry_h !== 1'b0 || sel_h !== 4'b0001 || seg_h !== 7'h3F)
            $display("FAIL restart count=%h carry=%b sel=%b seg=%h want 0001 0 0001 3f",
                     count_h, carry_h, sel_h, seg_h);
        else n_pass++;
    endtask

    task automatic test_load_priority();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            v = 16'($urandom);
            en = 1'b1; up = k[0]; load = 1'b1; load_val = v;
            step();
            n_checks++;
            if (count_h !== v || carry_h !== 1'b0)
                $display("FAIL load_priority count=%h carry=%b want %h 0", count_h, carry_h, v);
            else n_pass++;
        end
        load = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] picks [4];
        for (int k = 0; k < 400; k++) begin
            picks[0] = 16'($urandom); picks[1] = 16'hFFFF;
            picks[2] = 16'h0000;      picks[3] = 16'h9999;
            load     = ($urandom_range(0, 15) == 0);
            load_val = picks[$urandom_range(0, 3)];
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            blank_lz = ($urandom_range(0, 7) == 0) ? ~blank_lz : blank_lz;
            step();
            n_checks++;
            if ({count_h, carry_h, seg_h, sel_h} !== {16'(m_hex), m_carry_h, m_seg_h, m_sel})
                $display("FAIL rand_hex k=%0d got %h/%b/%h/%b want %h/%b/%h/%b", k, count_h,
                         carry_h, seg_h, sel_h, 16'(m_hex), m_carry_h, m_seg_h, m_sel);
            else n_pass++;
            n_checks++;
            if ({count_b, carry_b, seg_b, sel_b} !== {to_bcd(m_bcd), m_carry_b, m_seg_b, m_sel})
                $display("FAIL rand_bcd k=%0d got %h/%b/%h/%b want %h/%b/%h/%b", k, count_b,
                         carry_b, seg_b, sel_b, to_bcd(m_bcd), m_carry_b, m_seg_b, m_sel);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_bcd();
        test_scan();
        test_blank();
        test_async_reset();
        test_load_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
